// File: rtl/uart_transmitter_if.sv
// Handshake and serial-line bundle for uart_transmitter.
// master drives the write side; slave is the transmitter.
interface uart_transmitter_if;
  logic       tx_en;
  logic       tx_sample_tick;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_en, tx_sample_tick, tx_wr, tx_data,
    input  txd, tx_busy, tx_done
  );

  modport slave (
    input  tx_en, tx_sample_tick, tx_wr, tx_data,
    output txd, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter, LSB first, SAMPLES_PER_BIT ticks per bit.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frame).
module uart_transmitter #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input logic          clk,
  input logic          reset,
  uart_transmitter_if.slave bus
);

  localparam int CW = (SAMPLES_PER_BIT > 2) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(SAMPLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic          bit_end;

  // The final tick of a bit both ends the bit and triggers the transition.
  assign bit_end = bus.tx_sample_tick && (tick_cnt == LAST_TICK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      bus.txd     <= 1'b1;
      bus.tx_busy <= 1'b0;
      bus.tx_done <= 1'b0;
    end else if (!bus.tx_en) begin
      state       <= IDLE;
      shreg       <= '0;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      bus.txd     <= 1'b1;
      bus.tx_busy <= 1'b0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      if (state != IDLE && bus.tx_sample_tick && !bit_end)
        tick_cnt <= tick_cnt + CW'(1);
      case (state)
        IDLE: begin
          if (bus.tx_wr && !bus.tx_busy) begin
            shreg       <= bus.tx_data;
            state       <= START;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            bus.txd     <= 1'b0;
            bus.tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            tick_cnt <= '0;
            bus.txd  <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              bus.txd <= ^shreg;
`else
              state   <= STOP;
              bus.txd <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              bus.txd <= shreg[bit_idx + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            tick_cnt <= '0;
            bus.txd  <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bus.txd     <= 1'b1;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shape, tick scaling, ignored writes,
// async reset abort and tx_en abort. Follows UART_TX_PARITY_EN for frame length.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk;
  logic reset;
  int   tick_div;
  int   tick_phase;
  int   n_chk;
  int   n_pass;

  uart_transmitter_if bus ();

  uart_transmitter #(.SAMPLES_PER_BIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick generator: one pulse every tick_div clocks, updated on negedges.
  initial begin
    tick_phase = 0;
    bus.tx_sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_phase++;
      bus.tx_sample_tick = ((tick_phase % tick_div) == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f       = '1;
    f[0]    = 1'b0;
    f[8:1]  = d;
`ifdef UART_TX_PARITY_EN
    f[9]    = ^d;
`endif
    return f;
  endfunction

  // Write d, then follow the whole frame sampling each bit mid-way.
  // inject pulses tx_wr=0x55 mid-frame and on the STOP->IDLE edge.
  task automatic send_frame(input logic [7:0] d, input int div, input bit inject);
    int L, done_cnt, done_cyc;
    logic [10:0] fr;
    L        = 16 * div;
    tick_div = div;
    fr       = frame_of(d);
    done_cnt = 0;
    done_cyc = -1;
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_wr   = 1'b1;
    @(negedge clk);
    bus.tx_wr   = 1'b0;
    bus.tx_data = 8'h00;
    chk($sformatf("%h_busy_start", d), 32'(bus.tx_busy), 32'd1);
    chk($sformatf("%h_txd_start", d), 32'(bus.txd), 32'd0);
    for (int c = 0; c < NB * L + 4; c++) begin
      if (bus.tx_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c < NB * L && (c % L) == L / 2)
        chk($sformatf("%h_bit%0d", d, c / L), 32'(bus.txd), 32'(fr[c / L]));
      if (inject && (c == 40 || c == NB * L - 1)) begin
        bus.tx_wr   = 1'b1;
        bus.tx_data = 8'h55;
      end else begin
        bus.tx_wr   = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("%h_done_cnt", d), 32'(done_cnt), 32'd1);
    if (div == 1)
      chk($sformatf("%h_done_cyc", d), 32'(done_cyc), 32'(NB * 16));
    else
      chk($sformatf("%h_done_win", d), 32'(done_cyc > NB * L - div && done_cyc <= NB * L), 32'd1);
    chk($sformatf("%h_busy_end", d), 32'(bus.tx_busy), 32'd0);
    chk($sformatf("%h_txd_end", d), 32'(bus.txd), 32'd1);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    tick_div    = 1;
    reset       = 1'b1;
    bus.tx_en   = 1'b1;
    bus.tx_wr   = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(bus.txd), 32'd1);
    chk("rst_busy", 32'(bus.tx_busy), 32'd0);
    chk("rst_done", 32'(bus.tx_done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(8'hA5, 1, 1'b0);
    send_frame(8'h07, 1, 1'b0);
    send_frame(8'h3C, 4, 1'b0);
    send_frame(8'hC3, 1, 1'b1);

    // Reset in DATA bit 3 (cycle 72 after acceptance).
    tick_div = 1;
    @(negedge clk);
    bus.tx_data = 8'hF0;
    bus.tx_wr   = 1'b1;
    @(negedge clk);
    bus.tx_wr   = 1'b0;
    repeat (72) @(negedge clk);
    chk("pre_rst_txd", 32'(bus.txd), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_txd", 32'(bus.txd), 32'd1);
    chk("async_rst_busy", 32'(bus.tx_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_no_done%0d", i), 32'(bus.tx_done), 32'd0);
    end
    reset = 1'b0;
    send_frame(8'h81, 1, 1'b0);

    // tx_en dropped during START.
    @(negedge clk);
    bus.tx_data = 8'h5A;
    bus.tx_wr   = 1'b1;
    @(negedge clk);
    bus.tx_wr   = 1'b0;
    repeat (4) @(negedge clk);
    chk("en_start_txd", 32'(bus.txd), 32'd0);
    bus.tx_en = 1'b0;
    @(negedge clk);
    chk("en_abort_txd", 32'(bus.txd), 32'd1);
    chk("en_abort_busy", 32'(bus.tx_busy), 32'd0);
    bus.tx_data = 8'h12;
    bus.tx_wr   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.tx_wr = 1'b0;
      if (i % 5 == 0) begin
        chk($sformatf("en_off_busy%0d", i), 32'(bus.tx_busy), 32'd0);
        chk($sformatf("en_off_txd%0d", i), 32'(bus.txd), 32'd1);
        chk($sformatf("en_off_done%0d", i), 32'(bus.tx_done), 32'd0);
      end
    end
    bus.tx_en = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h12, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 16, is the number of tx_sample_tick pulses per serial bit; legal values are 2..256.
REQ-002 Port clk, input, 1 bit, is the single system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, is an asynchronous, active-high reset.
REQ-004 Port tx_en, input, 1 bit, is the block enable; while low, the block is held idle.
REQ-005 Port tx_sample_tick, input, 1 bit, is a one-clk pulse from the baud counter stage, asserted once per sample period.
REQ-006 Port tx_wr, input, 1 bit, is the one-clk write strobe requesting transmission of tx_data.
REQ-007 Port tx_data, input, 8 bits, is the byte to send; it is sampled only on an accepted tx_wr.
REQ-008 Port txd, output, 1 bit, is the serial line; it idles high and is registered.
REQ-009 Port tx_busy, output, 1 bit, is high while a frame is in progress.
REQ-010 Port tx_done, output, 1 bit, is a one-clk pulse when a frame completes normally.

Function
REQ-011 The state machine SHALL have the states IDLE, START, DATA, PARITY (present only per REQ-028), and STOP.
REQ-012 A tx_wr is accepted only when the state is IDLE, tx_en=1 and tx_busy=0; any other tx_wr SHALL be ignored, with no queuing.
REQ-013 On acceptance at edge N, tx_data SHALL be latched into an internal shift register; from edge N the state is START, txd=0 and tx_busy=1.
REQ-014 Each bit state SHALL hold txd constant for exactly SAMPLES_PER_BIT tx_sample_tick pulses, counted by an internal tick counter that is cleared on every state entry.
REQ-015 Cycles without tx_sample_tick SHALL NOT advance the tick counter; bit duration therefore scales with the tick rate.
REQ-016 Transitions occur on the edge at which the final tick of a bit is counted: START->DATA, DATA->DATA for bits 0..6, DATA->PARITY or STOP after bit 7, PARITY->STOP, STOP->IDLE.
REQ-017 Data SHALL be sent LSB first; bit index 0..7 is held in a 3-bit counter that wraps only on frame exit.
REQ-018 Line levels SHALL be: START txd=0; DATA txd=data[index]; STOP txd=1; IDLE txd=1.
REQ-019 On the STOP->IDLE edge, tx_busy SHALL go 0 and tx_done SHALL pulse high for exactly one clk.
REQ-020 A tx_wr arriving on the same cycle as the STOP->IDLE edge SHALL be ignored, because tx_busy is still 1 in that cycle.
REQ-021 If tx_en falls mid-frame, the next edge SHALL force IDLE with txd=1, tx_busy=0 and no tx_done; the latched byte is discarded.
REQ-022 A back-to-back write accepted on the first cycle after IDLE is re-entered SHALL start a new frame with no extra idle bit beyond the stop bit.
REQ-023 Internal counters SHALL be sized for SAMPLES_PER_BIT-1 and SHALL NOT overflow.

Reset
REQ-024 Asserting reset SHALL immediately set txd=1, tx_busy=0, tx_done=0, state IDLE, and all counters and the shift register to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no tx_done.
REQ-026 After reset deasserts, the first accepted tx_wr SHALL be handled normally.
REQ-027 Reset SHALL take priority over tx_en, tx_wr and tx_sample_tick.

Configuration
REQ-028 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL be compiled in and transmit even parity (the XOR of the 8 data bits) for one bit time, giving an 11-bit frame.
REQ-029 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP, giving a 10-bit frame.

Verification
REQ-030 Scenario: SAMPLES_PER_BIT=16, tick every clk, parity enabled, tx_wr with 0xA5 -> txd carries 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 16 clks; tx_done pulses 176 clks after acceptance.
REQ-031 Scenario: parity enabled, byte 0x07 -> parity bit is 1; parity disabled, byte 0x07 -> frame of 160 clks with no parity bit.
REQ-032 Scenario: tick every 4th clk, byte 0x3C -> each bit lasts 64 clks; txd is stable between ticks.
REQ-033 Scenario: tx_wr with 0x55 while busy, and again on the STOP->IDLE cycle -> both ignored; only the original frame is sent; tx_done pulses once.
REQ-034 Scenario: reset asserted in DATA bit 3 -> txd=1 and tx_busy=0 asynchronously, with no tx_done; a following tx_wr of 0x81 transmits correctly.
REQ-035 Scenario: tx_en dropped in START -> IDLE on the next edge, txd=1, no tx_done; tx_wr while tx_en=0 is ignored.
